// File: rtl/ctrl_pipe_chain_if.sv
// rtl/ctrl_pipe_chain_if.sv - control-word pipeline bus bundle
interface ctrl_pipe_chain_if #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 4
);
  logic [WIDTH-1:0]        in_ctrl;
  logic                    in_valid;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    in_ready;
  logic [STAGES*WIDTH-1:0] stage_ctrl;
  logic [STAGES-1:0]       stage_valid;
  logic                    retire;
  logic [CNT_W-1:0]        occupancy;

  modport master (
    output in_ctrl, in_valid, stall, flush,
    input  in_ready, stage_ctrl, stage_valid, retire, occupancy
  );

  modport slave (
    input  in_ctrl, in_valid, stall, flush,
    output in_ready, stage_ctrl, stage_valid, retire, occupancy
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - decoded control-word pipeline with stall, flush, bubbles and occupancy
module ctrl_pipe_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_pipe_chain_if.slave   bus
);

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             hold_prev;
  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0]             valid_d;
  logic [STAGES-1:0]             valid_prev;
  logic [STAGES-1:0][WIDTH-1:0]  ctrl_q;
  logic [STAGES-1:0][WIDTH-1:0]  ctrl_d;
  logic [STAGES-1:0][WIDTH-1:0]  ctrl_prev;
  logic [WIDTH-1:0]              in_word;
  logic [CNT_W-1:0]              occ_q;
  logic [CNT_W-1:0]              occ_d;

  // A stage holds when it or any stage downstream of it stalls.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = |(bus.stall >> k);
    end
  end

  // Decode acts as a virtual stage -1 that never holds; an invalid decode slot carries ctrl 0.
  assign in_word    = bus.in_valid ? bus.in_ctrl : '0;
  assign hold_prev  = {hold[STAGES-2:0], 1'b0};
  assign valid_prev = {valid_q[STAGES-2:0], bus.in_valid};
  assign ctrl_prev  = {ctrl_q[STAGES-2:0], in_word};

  // Next stage contents: flush beats hold, a held upstream stage injects a bubble, else shift.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    occ_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (bus.flush[k]) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end else if (hold[k]) begin
        valid_d[k] = valid_q[k];
        ctrl_d[k]  = ctrl_q[k];
      end else if (hold_prev[k]) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end else begin
        valid_d[k] = valid_prev[k];
        ctrl_d[k]  = ctrl_prev[k];
      end
      occ_d = occ_d + {{(CNT_W-1){1'b0}}, valid_d[k]};
    end
  end

  // Stage registers and occupancy; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.in_ready    = ~hold[0] & ~rst;
  assign bus.retire      = valid_q[STAGES-1] & ~hold[STAGES-1];
  assign bus.stage_ctrl  = ctrl_q;
  assign bus.stage_valid = valid_q;
  assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - scoreboard bench for ctrl_pipe_chain
module tb_ctrl_pipe_chain;

  typedef struct packed {
    logic        chk;
    logic        ir;
    logic        ret;
    logic [2:0]  sv;
    logic [47:0] sc;
    logic [3:0]  occ;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t q[$];

  ctrl_pipe_chain_if #(.WIDTH(16), .STAGES(3), .CNT_W(4)) bus ();

  ctrl_pipe_chain #(.WIDTH(16), .STAGES(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs for this cycle plus the outputs expected while they are applied.
  task automatic step(input logic r, input logic v, input logic [15:0] c,
                      input logic [2:0] st, input logic [2:0] fl,
                      input logic ck, input logic ir, input logic ret, input logic [2:0] sv,
                      input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                      input logic [3:0] occ);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.stall    = st;
    bus.flush    = fl;
    e.chk = ck;
    e.ir  = ir;
    e.ret = ret;
    e.sv  = sv;
    e.sc  = {w2, w1, w0};
    e.occ = occ;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("in_ready", 64'(bus.in_ready), 64'(e.ir));
      if (e.chk) begin
        chk("retire", 64'(bus.retire), 64'(e.ret));
        chk("stage_valid", 64'(bus.stage_valid), 64'(e.sv));
        chk("stage_ctrl", 64'(bus.stage_ctrl), 64'(e.sc));
        chk("occupancy", 64'(bus.occupancy), 64'(e.occ));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ctrl  = '0;
    bus.stall    = '0;
    bus.flush    = '0;

    // reset with live input
    step(1, 1, 16'hFFFF, 3'b000, 3'b000, 0, 0, 0, 3'b000, 16'h0,  16'h0,  16'h0, 4'd0);
    step(1, 1, 16'hFFFF, 3'b000, 3'b000, 1, 0, 0, 3'b000, 16'h0,  16'h0,  16'h0, 4'd0);
    // straight flow
    step(0, 1, 16'h0001, 3'b000, 3'b000, 1, 1, 0, 3'b000, 16'h0,  16'h0,  16'h0, 4'd0);
    step(0, 1, 16'h0002, 3'b000, 3'b000, 1, 1, 0, 3'b001, 16'h1,  16'h0,  16'h0, 4'd1);
    step(0, 1, 16'h0003, 3'b000, 3'b000, 1, 1, 0, 3'b011, 16'h2,  16'h1,  16'h0, 4'd2);
    step(0, 1, 16'h0004, 3'b000, 3'b000, 1, 1, 1, 3'b111, 16'h3,  16'h2,  16'h1, 4'd3);
    // mid stall on stage 1 for two cycles
    step(0, 1, 16'h0005, 3'b010, 3'b000, 1, 0, 1, 3'b111, 16'h4,  16'h3,  16'h2, 4'd3);
    step(0, 1, 16'h0005, 3'b010, 3'b000, 1, 0, 0, 3'b011, 16'h4,  16'h3,  16'h0, 4'd2);
    step(0, 1, 16'h0005, 3'b000, 3'b000, 1, 1, 0, 3'b011, 16'h4,  16'h3,  16'h0, 4'd2);
    step(0, 1, 16'h00A5, 3'b000, 3'b000, 1, 1, 1, 3'b111, 16'h5,  16'h4,  16'h3, 4'd3);
    step(0, 1, 16'h0006, 3'b000, 3'b000, 1, 1, 1, 3'b111, 16'hA5, 16'h5,  16'h4, 4'd3);
    // flush and stall stage 1 together while it holds 00A5
    step(0, 1, 16'h0007, 3'b010, 3'b010, 1, 0, 1, 3'b111, 16'h6,  16'hA5, 16'h5, 4'd3);
    step(0, 1, 16'h0007, 3'b000, 3'b000, 1, 1, 0, 3'b001, 16'h6,  16'h0,  16'h0, 4'd1);
    // decode bubble
    step(0, 0, 16'hBEEF, 3'b000, 3'b000, 1, 1, 0, 3'b011, 16'h7,  16'h6,  16'h0, 4'd2);
    step(0, 1, 16'h0008, 3'b000, 3'b000, 1, 1, 1, 3'b110, 16'h0,  16'h7,  16'h6, 4'd2);
    step(0, 1, 16'h0009, 3'b000, 3'b000, 1, 1, 1, 3'b101, 16'h8,  16'h0,  16'h7, 4'd2);
    step(0, 1, 16'h000A, 3'b000, 3'b000, 1, 1, 0, 3'b011, 16'h9,  16'h8,  16'h0, 4'd2);
    // full pipe, last stage stalled, then reset mid-stream
    step(0, 1, 16'h000B, 3'b100, 3'b000, 1, 0, 0, 3'b111, 16'hA,  16'h9,  16'h8, 4'd3);
    step(1, 1, 16'h000B, 3'b100, 3'b000, 1, 0, 0, 3'b111, 16'hA,  16'h9,  16'h8, 4'd3);
    step(0, 1, 16'h000C, 3'b000, 3'b000, 1, 1, 0, 3'b000, 16'h0,  16'h0,  16'h0, 4'd0);
    step(0, 0, 16'h0000, 3'b000, 3'b000, 1, 1, 0, 3'b001, 16'hC,  16'h0,  16'h0, 4'd1);
    // all-ones stall freezes the chain
    step(0, 0, 16'h0000, 3'b111, 3'b000, 1, 0, 0, 3'b010, 16'h0,  16'hC,  16'h0, 4'd1);
    // flush of stage 0 leaves other stages alone
    step(0, 1, 16'h000D, 3'b000, 3'b001, 1, 1, 0, 3'b010, 16'h0,  16'hC,  16'h0, 4'd1);
    step(0, 0, 16'h0000, 3'b000, 3'b000, 1, 1, 1, 3'b100, 16'h0,  16'h0,  16'hC, 4'd1);
    step(0, 0, 16'h0000, 3'b000, 3'b000, 1, 1, 0, 3'b000, 16'h0,  16'h0,  16'h0, 4'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
- Parametrised control-signal pipeline for the MIPS core. It carries the decoded control word from decode through STAGES downstream pipeline registers (E, M, W, ...).
- Replaces hand-instantiated per-stage flop groups with a single block.
- Adds per-stage stall (hold), per-stage flush, automatic bubble insertion, a valid bit per stage, and an occupancy counter.

Parameters:
- WIDTH, 16, bits in one control word.
- STAGES, 3, number of pipeline register stages after decode; legal range 2..8.
- CNT_W, 4, width of the occupancy counter; must satisfy 2^CNT_W > STAGES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_ctrl  in  WIDTH  control word from decode.
- in_valid  in  1  decode holds a real instruction.
- stall  in  STAGES  bit k requests stage k hold its contents this cycle.
- flush  in  STAGES  bit k clears stage k at the next edge.
- in_ready  out  1  stage 0 accepts in_ctrl this cycle.
- stage_ctrl  out  STAGES*WIDTH  registered control words; stage k occupies bits [k*WIDTH +: WIDTH].
- stage_valid  out  STAGES  registered valid per stage.
- retire  out  1  last stage holds a valid word and is not held this cycle.
- occupancy  out  CNT_W  registered count of set stage_valid bits.

Behaviour:
- Reset: on a rising edge with rst=1, all stage_ctrl are 0, all stage_valid are 0, occupancy is 0. rst has priority over every other input. A reset mid-stream discards all in-flight words.
- Hold chain (combinational): hold[k] = OR of stall[STAGES-1:k]. A downstream stall therefore freezes every upstream stage.
- in_ready = ~hold[0] & ~rst.
- retire = stage_valid[STAGES-1] & ~hold[STAGES-1].
- Per-stage update for stage k, in priority order (rst first, as above):
  1. flush[k]=1: valid<=0, ctrl<=0. Flush wins over hold.
  2. hold[k]=1: keep current contents.
  3. k=0: valid<=in_valid; ctrl<=in_valid ? in_ctrl : 0.
  4. k>0 and hold[k-1]=1: bubble, valid<=0, ctrl<=0.
  5. k>0 otherwise: copy stage k-1 (valid and ctrl).
- Invariant: a stage with valid=0 always presents ctrl=0. No stale control word may assert regwrite/memwrite downstream.
- Latency: an unstalled word presented at cycle t appears in stage k at cycle t+k+1. Throughput is one word per cycle.
- Last-stage contents leave the block when overwritten; there is no output handshake beyond retire.
- Occupancy is updated every edge to popcount of the next stage_valid vector. It is registered and matches stage_valid in the same cycle. Maximum value is STAGES; no wrap.
- Simultaneous flush[k] and stall[k]: stage k clears; upstream stages still hold because hold[k-1] includes stall[k].
- Flush of stage k does not affect stages j≠k.
- All-ones stall: the entire chain freezes and in_ready=0.
- Input accepted while in_ready=0 is ignored (upstream must hold it).

Test Plan:
- Reset: STAGES=3, WIDTH=16; hold rst 2 cycles with in_valid=1, in_ctrl=16'hFFFF -> all stage_valid=0, stage_ctrl=0, occupancy=0, in_ready=0 during rst.
- Straight flow: feed 16'h0001, 16'h0002, 16'h0003 on consecutive cycles -> 16'h0001 in stage 2 exactly 3 cycles after presentation; occupancy reaches 3; retire high in cycle 3.
- Mid stall: with the pipe full, assert stall[1] for 2 cycles -> stages 0 and 1 frozen, in_ready=0, stage 2 receives bubbles (valid=0, ctrl=0), occupancy drops 3->2; flow resumes in order with no lost or duplicated word.
- Flush during stall: assert stall[1] and flush[1] together with stage 1=16'h00A5 -> stage 1 becomes valid=0, ctrl=0; stage 0 holds; stage 2 gets a bubble.
- Decode flush: in_valid=0 for one cycle between words -> bubble with ctrl=0 travels the chain; occupancy never exceeds 2 during that bubble's passage.
- Reset mid-operation: pipe full with stall[2]=1, then rst=1 for one edge -> every stage clears on that edge; the next in_valid word enters stage 0 normally on the following cycle.
